pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning number of flops in the pll_locked synchroniser (legal 2..4).
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024, meaning the number of consecutive synchronised-high lock cycles required before reset hold begins (legal 1..65535).
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, meaning the number of cycles system reset stays asserted after lock is qualified (legal 1..255).
REQ-004 SHALL have parameter CE_DIV, default 16, meaning the clock-enable divide ratio, giving 52.0833 MHz / 16 = 3.255 MHz (legal 2..256).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock (PLL 52.0833 MHz output).
REQ-006 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL lock, asynchronous to clk.
REQ-008 SHALL have port sys_reset, output, 1 bit: active-high system reset.
REQ-009 SHALL have port sys_resetn, output, 1 bit: always the inverse of sys_reset.
REQ-010 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-011 SHALL have port ce, output, 1 bit: one-cycle clock-enable pulse.
REQ-012 SHALL have port loss_count, output, 8 bits: saturating count of lock losses.

Function
REQ-013 pll_locked SHALL pass through SYNC_STAGES flops; lk denotes the last flop; no other logic SHALL use pll_locked directly.
REQ-014 FSM states SHALL be WAIT_LOCK, STABLE, HOLD and RUN; all transitions SHALL be registered.
REQ-015 WAIT_LOCK: lk=1 -> STABLE, with the stable counter loaded to 1.
REQ-016 STABLE: lk=0 -> WAIT_LOCK, counter cleared, loss_count unchanged (a glitch during qualification is not a loss).
REQ-017 STABLE: lk=1 -> counter increments; when the counter = STABLE_CYCLES and lk=1 -> HOLD, hold counter cleared.
REQ-018 HOLD: lk=0 -> WAIT_LOCK with loss_count+1.
REQ-019 HOLD: lk=1 -> hold counter increments; after HOLD_CYCLES cycles in HOLD -> RUN.
REQ-020 RUN: lk=0 -> WAIT_LOCK with loss_count+1.
REQ-021 loss_count SHALL saturate at 255 with no wrap.
REQ-022 sys_reset SHALL be registered and equal 1 in every state except RUN; it SHALL be 0 from the first cycle in RUN.
REQ-023 ready SHALL be registered and asserted on the same cycle sys_reset deasserts.
REQ-024 Divider: counter 0..CE_DIV-1, counting only in RUN, held at 0 otherwise.
REQ-025 ce SHALL be 1 exactly when the divider = CE_DIV-1 and the state is RUN, giving the first pulse on the CE_DIV-th RUN cycle and then one pulse every CE_DIV cycles.
REQ-026 Leaving RUN SHALL force ce=0 on the next cycle and SHALL discard any partial divider phase.
REQ-027 All counters SHALL be sized to their parameter maximum with no overflow; the stable counter SHALL NOT increment past STABLE_CYCLES.

Reset
REQ-028 resetn=0 at a rising clk edge SHALL put the FSM in WAIT_LOCK and zero all counters, loss_count and the synchroniser flops.
REQ-029 While resetn=0, outputs SHALL be sys_reset=1, sys_resetn=0, ready=0, ce=0, loss_count=0.
REQ-030 Reset asserted in mid-sequence (any state, including RUN) SHALL take effect on the next edge, with identical results.
REQ-031 resetn=0 SHALL override any simultaneous lk change.

Verification
REQ-032 Power-up: resetn low 4 cycles, pll_locked=1 constant (defaults) -> sys_reset falls exactly SYNC_STAGES+1024+16 (+/-1 FSM registration) cycles after resetn rises; ready rises on the same cycle; first ce 16 cycles later, then every 16 cycles.
REQ-033 Qualification glitch: pll_locked low for 1 cycle at STABLE count 500 -> return to WAIT_LOCK, full 1024 requalification required, loss_count stays 0.
REQ-034 Loss in RUN: drop pll_locked for 10 cycles -> sys_reset=1 and ce=0 within SYNC_STAGES+1 cycles; loss_count=1; full sequence repeats after relock.
REQ-035 Saturation: force 300 losses (in HOLD or RUN) -> loss_count=255.
REQ-036 Mid-run reset: resetn=0 for 1 cycle in RUN with loss_count=3 -> next cycle state WAIT_LOCK, loss_count=0, sys_reset=1.
REQ-037 Parameter sweep: CE_DIV=2 and STABLE_CYCLES=1, HOLD_CYCLES=1 -> ce toggles every other RUN cycle and sequence timing scales exactly.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL lock qualification and system reset sequencer.
// Synchronises pll_locked, qualifies lock, holds reset, then runs a divided clock enable.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CE_DIV        = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_locked,
  output logic       sys_reset,
  output logic       sys_resetn,
  output logic       ready,
  output logic       ce,
  output logic [7:0] loss_count
);

  // state     | meaning
  // WAIT_LOCK | waiting for synchronised lock
  // STABLE    | counting consecutive lock cycles
  // HOLD      | lock qualified, system reset still held
  // RUN       | reset released, clock enable running
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam int DCW = $clog2(CE_DIV);
  localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES);
  localparam logic [HCW-1:0] HOLD_LAST   = HCW'(HOLD_CYCLES - 1);
  localparam logic [DCW-1:0] DIV_LAST    = DCW'(CE_DIV - 1);
  localparam logic [DCW-1:0] DIV_PRE     = DCW'(CE_DIV - 2);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lk;
  logic [SCW-1:0]         stable_cnt;
  logic [HCW-1:0]         hold_cnt;
  logic [DCW-1:0]         div_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) sync <= '0;
    else         sync <= {sync[SYNC_STAGES-2:0], pll_locked};
  end

  assign lk         = sync[SYNC_STAGES-1];
  assign sys_resetn = ~sys_reset;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= WAIT_LOCK;
      stable_cnt <= '0;
      hold_cnt   <= '0;
      div_cnt    <= '0;
      loss_count <= '0;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
      ce         <= 1'b0;
    end else begin
      // Outside RUN the reset is held and any divider phase is dropped.
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      ce        <= 1'b0;
      div_cnt   <= '0;
      case (state)
        WAIT_LOCK: begin
          if (lk) begin
            state      <= STABLE;
            stable_cnt <= SCW'(1);
          end
        end
        STABLE: begin
          if (!lk) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
          end else if (stable_cnt == STABLE_LAST) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!lk) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
            if (loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            sys_reset <= 1'b0;
            ready     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
            if (loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
          end else begin
            sys_reset <= 1'b0;
            ready     <= 1'b1;
            ce        <= (div_cnt == DIV_PRE);
            div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: default instance plus a fast-parameter instance,
// both checked every cycle against a lock-run-length model, with directed literal timing checks.
module tb_pll_reset_sequencer;

  localparam int SS_A = 2, S_A = 1024, H_A = 16, CE_A = 16;
  localparam int SS_B = 3, S_B = 1,    H_B = 1,  CE_B = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sys_reset_a, sys_resetn_a, ready_a, ce_a;
  logic       sys_reset_b, sys_resetn_b, ready_b, ce_b;
  logic [7:0] loss_a_dut, loss_b_dut;

  always #5 clk = ~clk;

  pll_reset_sequencer dut_a (
    .clk(clk), .resetn(resetn), .pll_locked(pll_locked),
    .sys_reset(sys_reset_a), .sys_resetn(sys_resetn_a), .ready(ready_a),
    .ce(ce_a), .loss_count(loss_a_dut)
  );

  pll_reset_sequencer #(
    .SYNC_STAGES(SS_B), .STABLE_CYCLES(S_B), .HOLD_CYCLES(H_B), .CE_DIV(CE_B)
  ) dut_b (
    .clk(clk), .resetn(resetn), .pll_locked(pll_locked),
    .sys_reset(sys_reset_b), .sys_resetn(sys_resetn_b), .ready(ready_b),
    .ce(ce_b), .loss_count(loss_b_dut)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: n = consecutive synchronised-high lock cycles since the last low or reset.
  // 0 -> waiting, 1..S -> qualifying, S+1..S+H -> holding, beyond -> running.
  bit model_on = 1'b0;
  bit hist[$];
  int n_a = 0, n_b = 0, loss_a = 0, loss_b = 0;
  bit la, lb;

  function automatic bit lk_at(input int ss);
    return (hist.size() >= ss) ? hist[hist.size() - ss] : 1'b0;
  endfunction

  task automatic step(input bit lk, input int s, inout int n, inout int loss);
    if (lk) n++;
    else begin
      if (n > s) loss = (loss < 255) ? loss + 1 : 255;
      n = 0;
    end
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      hist.delete();
      n_a = 0; n_b = 0; loss_a = 0; loss_b = 0;
      model_on = 1'b1;
    end else begin
      la = lk_at(SS_A);
      lb = lk_at(SS_B);
      step(la, S_A, n_a, loss_a);
      step(lb, S_B, n_b, loss_b);
      hist.push_back(pll_locked);
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  task automatic cmp_inst(input string tag, input int n, input int loss, input int s,
                          input int h, input int cdiv, input logic sr, input logic srn,
                          input logic rdy, input logic cee, input logic [7:0] lc);
    bit run;
    bit ce_exp;
    run    = (n > s + h);
    ce_exp = run && (((n - s - h) % cdiv) == 0);
    chk({tag, ".sys_reset"},  int'(sr),  int'(!run));
    chk({tag, ".sys_resetn"}, int'(srn), int'(run));
    chk({tag, ".ready"},      int'(rdy), int'(run));
    chk({tag, ".ce"},         int'(cee), int'(ce_exp));
    chk({tag, ".loss_count"}, int'(lc),  loss);
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      cmp_inst("a", n_a, loss_a, S_A, H_A, CE_A, sys_reset_a, sys_resetn_a, ready_a, ce_a, loss_a_dut);
      cmp_inst("b", n_b, loss_b, S_B, H_B, CE_B, sys_reset_b, sys_resetn_b, ready_b, ce_b, loss_b_dut);
    end
  end

  function automatic bit probe(input int sel);
    case (sel)
      0:       return ce_a;
      1:       return ce_b;
      default: return !sys_reset_a;
    endcase
  endfunction

  // Counts rising edges until the probed signal is seen high at a falling edge.
  task automatic edges_until(input int sel, output int c);
    c = 0;
    do begin
      @(posedge clk);
      c++;
      @(negedge clk);
    end while (!probe(sel) && c < 5000);
  endtask

  int cnt, fall_b, c, r, len, cyc;

  initial begin
    // Power-up with lock already present.
    resetn = 1'b0;
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_sys_reset_a", int'(sys_reset_a), 1);
    chk("reset_loss_a", int'(loss_a_dut), 0);
    resetn = 1'b1;
    cnt = 0;
    fall_b = 0;
    while (sys_reset_a && cnt < 3000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (fall_b == 0 && !sys_reset_b) fall_b = cnt;
    end
    // Edges counted from the first one with resetn high: 2 sync + 1024 + 16, plus that first edge.
    chk("powerup_fall_a", cnt, 1043);
    chk("powerup_ready_a", int'(ready_a), 1);
    // Fast instance: 3 sync + 1 + 1, plus the first edge.
    chk("powerup_fall_b", fall_b, 6);
    edges_until(0, c);
    chk("first_ce_a", c, 15);
    edges_until(0, c);
    chk("ce_period_a", c, 16);
    edges_until(1, c);
    edges_until(1, c);
    chk("ce_period_b", c, 2);

    // One-cycle lock glitch while qualifying around count 500.
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (500) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    edges_until(2, c);
    chk("requalify_a", c, 1043);
    chk("glitch_no_loss_a", int'(loss_a_dut), 0);

    // Ten-cycle lock loss while running.
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("loss_sys_reset_a", int'(sys_reset_a), 1);
    chk("loss_ce_a", int'(ce_a), 0);
    repeat (7) @(negedge clk);
    pll_locked = 1'b1;
    chk("loss_count_a", int'(loss_a_dut), 1);
    edges_until(2, c);
    chk("relock_a", c, 1043);

    for (int k = 2; k <= 3; k++) begin
      pll_locked = 1'b0;
      repeat (4) @(negedge clk);
      pll_locked = 1'b1;
      edges_until(2, c);
      chk("loss_accum_a", int'(loss_a_dut), k);
    end

    // One-cycle reset while running with three recorded losses.
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midrun_loss_a", int'(loss_a_dut), 0);
    chk("midrun_sys_reset_a", int'(sys_reset_a), 1);
    chk("midrun_ready_a", int'(ready_a), 0);

    // 300 losses on the fast instance; the default one never qualifies.
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b1;
      repeat (4) @(negedge clk);
      pll_locked = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (SS_B + 2) @(negedge clk);
    chk("saturate_b", int'(loss_b_dut), 255);
    chk("saturate_a_untouched", int'(loss_a_dut), 0);

    // Random lock activity with rare resets, checked by the model every cycle.
    cyc = 0;
    while (cyc < 20000) begin
      r = $urandom_range(0, 9);
      if (r < 6)      len = $urandom_range(1, 12);
      else if (r < 8) len = $urandom_range(1020, 1050);
      else            len = $urandom_range(1050, 1200);
      pll_locked = 1'b1;
      for (int i = 0; i < len; i++) begin
        resetn = ($urandom_range(0, 3999) == 0) ? 1'b0 : 1'b1;
        @(negedge clk);
        cyc++;
      end
      resetn = 1'b1;
      pll_locked = 1'b0;
      len = $urandom_range(1, 6);
      repeat (len) @(negedge clk);
      cyc += len;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
